active_list_commit_reader: RTL and testbench

//  In-order retire side of the active list: reads up to COMMIT_WIDTH head entries per cycle, decides how

---
 rtl/active_list_commit_reader_pkg.sv | 62 ++++++
 rtl/active_list_commit_reader_if.sv | 36 +++
 rtl/active_list_commit_reader_commit_lane_selector.sv | 63 ++++++
 rtl/active_list_commit_reader.sv | 133 +++++++++++++
 tb/tb_active_list_commit_reader.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/active_list_commit_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : active_list_commit_reader_pkg
// Description : Shared rename/active-list types and constants for the commit reader.
// Revision    : 1.0 - initial release
// ============================================================================
package active_list_commit_reader_pkg;

    localparam int COMMIT_WIDTH      = 2;
    localparam int AL_ENTRY_NUM_BITS = 6;
    localparam int PHY_REG_BITS      = 7;
    localparam int PC_WIDTH          = 32;
    localparam int LANE_IDX_BITS     = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;

    typedef logic [PC_WIDTH-1:0]                PC_Path;
    typedef logic [PHY_REG_BITS-1:0]            PhyRegNum;
    typedef logic [AL_ENTRY_NUM_BITS:0]         ActiveListCount;
    typedef logic [$clog2(COMMIT_WIDTH+1)-1:0]  CommitLaneCount;
    typedef logic [LANE_IDX_BITS-1:0]           CommitLaneIndex;

    // Memory-map trap vector for undefined/unsupported operations
    localparam PC_Path TRAP_PC_DEFAULT = PC_Path'(32'h0000_1000);

    typedef enum logic [1:0] {
        EXEC_NOT_FINISHED = 2'd0,
        EXEC_SUCCESS      = 2'd1,
        EXEC_REFETCH_THIS = 2'd2,
        EXEC_REFETCH_NEXT = 2'd3
    } ExecState;

    typedef enum logic [1:0] {
        RECOVER_NONE         = 2'd0,
        RECOVER_REFETCH_THIS = 2'd1,
        RECOVER_REFETCH_NEXT = 2'd2,
        RECOVER_TRAP         = 2'd3
    } RecoveryKind;

    typedef enum logic [0:0] {
        ST_NORMAL     = 1'b0,
        ST_RECOVERING = 1'b1
    } CommitState;

    typedef struct packed {
        PC_Path   pc;
        PhyRegNum phyPrevDstRegNum;
        logic     writeReg;
        logic     isEnv;
        logic     undefined;
        logic     last;
    } ActiveListEntry;

    function automatic CommitLaneCount count_ones(input logic [COMMIT_WIDTH-1:0] v);
        CommitLaneCount n;
        n = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            n = n + CommitLaneCount'(v[i]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/active_list_commit_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : active_list_commit_reader_if
// Description : Active-list head / commit bus between the active list and the commit reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface active_list_commit_reader_if;
    import active_list_commit_reader_pkg::*;

    ActiveListCount                    alValidEntryNum;
    ActiveListEntry [COMMIT_WIDTH-1:0] headEntry;
    ExecState       [COMMIT_WIDTH-1:0] headExecState;
    logic                              storeQueueEmpty;

    logic           [COMMIT_WIDTH-1:0] commit;
    CommitLaneCount                    popHeadNum;
    logic           [COMMIT_WIDTH-1:0] releaseReg;
    PhyRegNum       [COMMIT_WIDTH-1:0] releasePhyReg;
    logic                              recoverReq;
    PC_Path                            recoveredPC;
    logic                              flushing;
    logic           [63:0]             retiredInsnCnt;

    modport master (
        output alValidEntryNum, headEntry, headExecState, storeQueueEmpty,
        input  commit, popHeadNum, releaseReg, releasePhyReg,
               recoverReq, recoveredPC, flushing, retiredInsnCnt
    );

    modport slave (
        input  alValidEntryNum, headEntry, headExecState, storeQueueEmpty,
        output commit, popHeadNum, releaseReg, releasePhyReg,
               recoverReq, recoveredPC, flushing, retiredInsnCnt
    );
endinterface
`default_nettype wire

// File: rtl/active_list_commit_reader_commit_lane_selector.sv
`default_nettype none
// ============================================================================
// Module      : commit_lane_selector
// Description : Combinational prefix eligibility of head lanes plus first-blocker recovery kind/index.
// Revision    : 1.0 - initial release
// ============================================================================
module commit_lane_selector
    import active_list_commit_reader_pkg::*;
(
    input  logic                               enable,
    input  ActiveListCount                     valid_num,
    input  ExecState       [COMMIT_WIDTH-1:0]  exec_state,
    input  logic           [COMMIT_WIDTH-1:0]  is_env,
    input  logic           [COMMIT_WIDTH-1:0]  undefined,
    input  logic                               store_queue_empty,
    output logic           [COMMIT_WIDTH-1:0]  commit,
    output RecoveryKind                        kind,
    output CommitLaneIndex                     blocker_idx
);

    logic w_blocked;
    logic w_ok;

    always_comb begin
        commit      = '0;
        kind        = RECOVER_NONE;
        blocker_idx = '0;
        w_blocked   = !enable;
        w_ok        = 1'b0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (!w_blocked) begin
                if (ActiveListCount'(i) >= valid_num) begin
                    w_blocked = 1'b1;
                end else begin
                    w_ok = (exec_state[i] == EXEC_SUCCESS || exec_state[i] == EXEC_REFETCH_NEXT)
                           && !undefined[i]
                           && (!is_env[i] || (i == 0 && store_queue_empty));
                    if (w_ok) begin
                        commit[i] = 1'b1;
                        // A retiring env op or refetch-next op closes the commit group
                        if (exec_state[i] == EXEC_REFETCH_NEXT) begin
                            kind        = RECOVER_REFETCH_NEXT;
                            blocker_idx = CommitLaneIndex'(i);
                            w_blocked   = 1'b1;
                        end else if (is_env[i]) begin
                            w_blocked = 1'b1;
                        end
                    end else begin
                        w_blocked   = 1'b1;
                        blocker_idx = CommitLaneIndex'(i);
                        if (undefined[i] && exec_state[i] != EXEC_NOT_FINISHED) begin
                            kind = RECOVER_TRAP;
                        end else if (exec_state[i] == EXEC_REFETCH_THIS) begin
                            kind = RECOVER_REFETCH_THIS;
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/active_list_commit_reader.sv
`default_nettype none
// ============================================================================
// Module      : active_list_commit_reader
// Description : In-order retire of active-list head entries with recovery request and drain window.
// Revision    : 1.0 - initial release
// ============================================================================
module active_list_commit_reader
    import active_list_commit_reader_pkg::*;
#(
    parameter int     RECOVERY_CYCLES = 3,
    parameter PC_Path TRAP_PC         = TRAP_PC_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    active_list_commit_reader_if.slave bus
);

    localparam int c_cnt_bits = $clog2(RECOVERY_CYCLES + 1);

    CommitState                      r_state;
    logic [c_cnt_bits-1:0]           r_cnt;
    logic                            r_recover_req;
    PC_Path                          r_recovered_pc;
    logic                            r_flushing;
    logic [63:0]                     r_retired;

    logic     [COMMIT_WIDTH-1:0]     w_is_env;
    logic     [COMMIT_WIDTH-1:0]     w_undefined;
    logic     [COMMIT_WIDTH-1:0]     w_commit;
    logic     [COMMIT_WIDTH-1:0]     w_release_reg;
    PhyRegNum [COMMIT_WIDTH-1:0]     w_release_phy;
    CommitLaneCount                  w_retire_cnt;
    RecoveryKind                     w_kind;
    CommitLaneIndex                  w_blk_idx;
    PC_Path                          w_target_pc;
    logic                            w_enable;

    assign w_enable = (r_state == ST_NORMAL) && !rst;

    always_comb begin
        w_is_env    = '0;
        w_undefined = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            w_is_env[i]    = bus.headEntry[i].isEnv;
            w_undefined[i] = bus.headEntry[i].undefined;
        end
    end

    commit_lane_selector u_selector (
        .enable            (w_enable),
        .valid_num         (bus.alValidEntryNum),
        .exec_state        (bus.headExecState),
        .is_env            (w_is_env),
        .undefined         (w_undefined),
        .store_queue_empty (bus.storeQueueEmpty),
        .commit            (w_commit),
        .kind              (w_kind),
        .blocker_idx       (w_blk_idx)
    );

    always_comb begin
        w_release_reg = '0;
        w_release_phy = '0;
        w_retire_cnt  = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            w_release_reg[i] = w_commit[i] && bus.headEntry[i].writeReg;
            if (w_release_reg[i]) begin
                w_release_phy[i] = bus.headEntry[i].phyPrevDstRegNum;
            end
            if (w_commit[i] && bus.headEntry[i].last) begin
                w_retire_cnt = w_retire_cnt + CommitLaneCount'(1);
            end
        end
    end

    always_comb begin
        w_target_pc = '0;
        case (w_kind)
            RECOVER_TRAP:         w_target_pc = TRAP_PC;
            RECOVER_REFETCH_THIS: w_target_pc = bus.headEntry[w_blk_idx].pc;
            RECOVER_REFETCH_NEXT: w_target_pc = bus.headEntry[w_blk_idx].pc + PC_Path'(4);
            default:              w_target_pc = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_NORMAL;
            r_cnt          <= '0;
            r_recover_req  <= 1'b0;
            r_recovered_pc <= '0;
            r_flushing     <= 1'b0;
            r_retired      <= '0;
        end else begin
            r_recover_req <= 1'b0;
            r_retired     <= r_retired + 64'(w_retire_cnt);
            case (r_state)
                ST_NORMAL: begin
                    if (w_kind != RECOVER_NONE) begin
                        r_state        <= ST_RECOVERING;
                        r_cnt          <= c_cnt_bits'(RECOVERY_CYCLES);
                        r_recover_req  <= 1'b1;
                        r_recovered_pc <= w_target_pc;
                        r_flushing     <= 1'b1;
                    end
                end
                ST_RECOVERING: begin
                    // Flushing stays high for exactly RECOVERY_CYCLES cycles
                    r_cnt <= r_cnt - c_cnt_bits'(1);
                    if (r_cnt <= c_cnt_bits'(1)) begin
                        r_state    <= ST_NORMAL;
                        r_flushing <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_NORMAL;
                    r_flushing <= 1'b0;
                end
            endcase
        end
    end

    assign bus.commit         = w_commit;
    assign bus.popHeadNum     = count_ones(w_commit);
    assign bus.releaseReg     = w_release_reg;
    assign bus.releasePhyReg  = w_release_phy;
    assign bus.recoverReq     = r_recover_req;
    assign bus.recoveredPC    = r_recovered_pc;
    assign bus.flushing       = r_flushing;
    assign bus.retiredInsnCnt = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_active_list_commit_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_active_list_commit_reader
// Description : Directed table-driven and sequence checks for active_list_commit_reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_active_list_commit_reader;
    import active_list_commit_reader_pkg::*;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    active_list_commit_reader_if bus ();

    active_list_commit_reader #(
        .RECOVERY_CYCLES (3),
        .TRAP_PC         (PC_Path'(32'h1000))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string          name;
        ActiveListCount al;
        ExecState       e0;
        ExecState       e1;
        ActiveListEntry h0;
        ActiveListEntry h1;
        logic           sq;
        logic [1:0]     exp_commit;
        logic [1:0]     exp_rel;
        logic           exp_rec;
        PC_Path         exp_pc;
        logic [63:0]    exp_cnt;
    } vec_t;

    vec_t vecs[15];

    function automatic ActiveListEntry ent(input PC_Path pc, input int prev, input logic wr,
                                           input logic env, input logic undf, input logic last);
        ActiveListEntry e;
        e.pc               = pc;
        e.phyPrevDstRegNum = PhyRegNum'(prev);
        e.writeReg         = wr;
        e.isEnv            = env;
        e.undefined        = undf;
        e.last             = last;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic apply(input ActiveListCount al, input ExecState e0, input ExecState e1,
                         input ActiveListEntry h0, input ActiveListEntry h1, input logic sq);
        bus.alValidEntryNum  = al;
        bus.headExecState[0] = e0;
        bus.headExecState[1] = e1;
        bus.headEntry[0]     = h0;
        bus.headEntry[1]     = h1;
        bus.storeQueueEmpty  = sq;
    endtask

    task automatic do_reset();
        apply('0, EXEC_NOT_FINISHED, EXEC_NOT_FINISHED, '0, '0, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    ActiveListEntry a0, a1;
    int pulses;

    initial begin
        n_pass  = 0;
        n_total = 0;
        a0 = ent(32'h100, 10, 1'b1, 1'b0, 1'b0, 1'b1);
        a1 = ent(32'h104, 11, 1'b1, 1'b0, 1'b0, 1'b1);

        vecs[0]  = '{"both_success", 7'd2, EXEC_SUCCESS, EXEC_SUCCESS, a0, a1, 1'b1, 2'b11, 2'b11, 1'b0, 32'h0, 64'd2};
        vecs[1]  = '{"lane0_not_finished", 7'd2, EXEC_NOT_FINISHED, EXEC_SUCCESS, a0, a1, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0, 64'd0};
        vecs[2]  = '{"refetch_this_lane1", 7'd2, EXEC_SUCCESS, EXEC_REFETCH_THIS, a0, ent(32'h2008, 11, 1'b1, 1'b0, 1'b0, 1'b1), 1'b1, 2'b01, 2'b01, 1'b1, 32'h2008, 64'd1};
        vecs[3]  = '{"refetch_next_lane0", 7'd2, EXEC_REFETCH_NEXT, EXEC_SUCCESS, ent(32'h3000, 10, 1'b1, 1'b0, 1'b0, 1'b1), a1, 1'b1, 2'b01, 2'b01, 1'b1, 32'h3004, 64'd1};
        vecs[4]  = '{"undefined_lane0", 7'd2, EXEC_SUCCESS, EXEC_SUCCESS, ent(32'h100, 10, 1'b1, 1'b0, 1'b1, 1'b1), a1, 1'b1, 2'b00, 2'b00, 1'b1, 32'h1000, 64'd0};
        vecs[5]  = '{"al1_ignores_lane1", 7'd1, EXEC_SUCCESS, EXEC_REFETCH_THIS, a0, a1, 1'b1, 2'b01, 2'b01, 1'b0, 32'h0, 64'd1};
        vecs[6]  = '{"al0_empty", 7'd0, EXEC_SUCCESS, EXEC_SUCCESS, a0, a1, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0, 64'd0};
        vecs[7]  = '{"env_sq_busy", 7'd2, EXEC_SUCCESS, EXEC_SUCCESS, ent(32'h100, 10, 1'b1, 1'b1, 1'b0, 1'b1), a1, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 64'd0};
        vecs[8]  = '{"env_sq_empty_alone", 7'd2, EXEC_SUCCESS, EXEC_SUCCESS, ent(32'h100, 10, 1'b1, 1'b1, 1'b0, 1'b1), a1, 1'b1, 2'b01, 2'b01, 1'b0, 32'h0, 64'd1};
        vecs[9]  = '{"env_in_lane1", 7'd2, EXEC_SUCCESS, EXEC_SUCCESS, a0, ent(32'h104, 11, 1'b1, 1'b1, 1'b0, 1'b1), 1'b1, 2'b01, 2'b01, 1'b0, 32'h0, 64'd1};
        vecs[10] = '{"nowrite_nolast", 7'd2, EXEC_SUCCESS, EXEC_SUCCESS, ent(32'h100, 10, 1'b0, 1'b0, 1'b0, 1'b0), a1, 1'b1, 2'b11, 2'b10, 1'b0, 32'h0, 64'd1};
        vecs[11] = '{"undef_lane1_refetch", 7'd2, EXEC_SUCCESS, EXEC_REFETCH_THIS, a0, ent(32'h104, 11, 1'b1, 1'b0, 1'b1, 1'b1), 1'b1, 2'b01, 2'b01, 1'b1, 32'h1000, 64'd1};
        vecs[12] = '{"undef_lane1_nf", 7'd2, EXEC_SUCCESS, EXEC_NOT_FINISHED, a0, ent(32'h104, 11, 1'b1, 1'b0, 1'b1, 1'b1), 1'b1, 2'b01, 2'b01, 1'b0, 32'h0, 64'd1};
        vecs[13] = '{"refetch_this_lane0", 7'd2, EXEC_REFETCH_THIS, EXEC_SUCCESS, a0, a1, 1'b1, 2'b00, 2'b00, 1'b1, 32'h100, 64'd0};
        vecs[14] = '{"refetch_next_lane1", 7'd2, EXEC_SUCCESS, EXEC_REFETCH_NEXT, a0, a1, 1'b1, 2'b11, 2'b11, 1'b1, 32'h108, 64'd2};

        // Reset state, with lanes that would otherwise commit
        rst = 1'b1;
        apply(7'd2, EXEC_SUCCESS, EXEC_SUCCESS, a0, a1, 1'b1);
        @(posedge clk); #1;
        check("rst_commit", 64'(bus.commit), 64'd0);
        check("rst_pop", 64'(bus.popHeadNum), 64'd0);
        check("rst_release", 64'(bus.releaseReg), 64'd0);
        check("rst_recoverReq", 64'(bus.recoverReq), 64'd0);
        check("rst_recoveredPC", 64'(bus.recoveredPC), 64'd0);
        check("rst_flushing", 64'(bus.flushing), 64'd0);
        check("rst_cnt", bus.retiredInsnCnt, 64'd0);

        for (int i = 0; i < 15; i++) begin
            do_reset();
            apply(vecs[i].al, vecs[i].e0, vecs[i].e1, vecs[i].h0, vecs[i].h1, vecs[i].sq);
            #1;
            check({vecs[i].name, "_commit"}, 64'(bus.commit), 64'(vecs[i].exp_commit));
            check({vecs[i].name, "_pop"}, 64'(bus.popHeadNum),
                  64'(vecs[i].exp_commit[0]) + 64'(vecs[i].exp_commit[1]));
            check({vecs[i].name, "_releaseReg"}, 64'(bus.releaseReg), 64'(vecs[i].exp_rel));
            check({vecs[i].name, "_releasePhy0"}, 64'(bus.releasePhyReg[0]),
                  vecs[i].exp_rel[0] ? 64'(vecs[i].h0.phyPrevDstRegNum) : 64'd0);
            check({vecs[i].name, "_releasePhy1"}, 64'(bus.releasePhyReg[1]),
                  vecs[i].exp_rel[1] ? 64'(vecs[i].h1.phyPrevDstRegNum) : 64'd0);
            @(posedge clk); #1;
            check({vecs[i].name, "_recoverReq"}, 64'(bus.recoverReq), 64'(vecs[i].exp_rec));
            check({vecs[i].name, "_flushing"}, 64'(bus.flushing), 64'(vecs[i].exp_rec));
            check({vecs[i].name, "_recoveredPC"}, 64'(bus.recoveredPC), 64'(vecs[i].exp_pc));
            check({vecs[i].name, "_cnt"}, bus.retiredInsnCnt, vecs[i].exp_cnt);
        end

        // Refetch-this: single pulse, three flushing cycles with commit blocked, then resume
        do_reset();
        apply(7'd2, EXEC_SUCCESS, EXEC_REFETCH_THIS, a0, ent(32'h2008, 11, 1'b1, 1'b0, 1'b0, 1'b1), 1'b1);
        #1;
        check("seq_rt_commit", 64'(bus.commit), 64'b01);
        @(posedge clk); #1;
        check("seq_rt_pc", 64'(bus.recoveredPC), 64'h2008);
        apply(7'd2, EXEC_SUCCESS, EXEC_SUCCESS, a0, a1, 1'b1);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("seq_rt_flushing", 64'(bus.flushing), 64'd1);
            check("seq_rt_blocked", 64'(bus.commit), 64'd0);
            check("seq_rt_pulse", 64'(bus.recoverReq), (k == 0) ? 64'd1 : 64'd0);
            @(posedge clk); #1;
        end
        check("seq_rt_flush_end", 64'(bus.flushing), 64'd0);
        check("seq_rt_resume", 64'(bus.commit), 64'b11);

        // Refetch-next held at head: exactly one pulse within the drain window
        do_reset();
        apply(7'd2, EXEC_REFETCH_NEXT, EXEC_SUCCESS, ent(32'h3000, 10, 1'b1, 1'b0, 1'b0, 1'b1), a1, 1'b1);
        #1;
        check("seq_rn_commit", 64'(bus.commit), 64'b01);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (bus.recoverReq) pulses++;
        end
        check("seq_rn_pulses", 64'(pulses), 64'd1);
        check("seq_rn_pc", 64'(bus.recoveredPC), 64'h3004);
        check("seq_rn_cnt", bus.retiredInsnCnt, 64'd1);
        @(posedge clk); #1;
        check("seq_rn_recommit", 64'(bus.commit), 64'b01);

        // Env op waits for the store queue to drain, then retires alone
        do_reset();
        apply(7'd2, EXEC_SUCCESS, EXEC_SUCCESS, ent(32'h100, 10, 1'b1, 1'b1, 1'b0, 1'b1), a1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("seq_env_stall", 64'(bus.commit), 64'd0);
            @(posedge clk); #1;
        end
        check("seq_env_no_recover", 64'(bus.flushing), 64'd0);
        bus.storeQueueEmpty = 1'b1;
        #1;
        check("seq_env_commit", 64'(bus.commit), 64'b01);
        check("seq_env_pop", 64'(bus.popHeadNum), 64'd1);

        // Undefined op trap, then reset while flushing
        do_reset();
        apply(7'd2, EXEC_SUCCESS, EXEC_SUCCESS, ent(32'h100, 10, 1'b1, 1'b0, 1'b1, 1'b1), a1, 1'b1);
        #1;
        check("seq_ud_commit", 64'(bus.commit), 64'd0);
        @(posedge clk); #1;
        check("seq_ud_pulse", 64'(bus.recoverReq), 64'd1);
        check("seq_ud_pc", 64'(bus.recoveredPC), 64'h1000);
        check("seq_ud_flushing", 64'(bus.flushing), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        apply(7'd2, EXEC_SUCCESS, EXEC_SUCCESS, a0, a1, 1'b1);
        #1;
        check("seq_ud_rst_flushing", 64'(bus.flushing), 64'd0);
        check("seq_ud_rst_pulse", 64'(bus.recoverReq), 64'd0);
        check("seq_ud_rst_normal", 64'(bus.commit), 64'b11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
